seg7_out: RTL and testbench
===========================

# seg7_out

Memory-mapped eight-digit seven-segment display controller on the I/O write path. It captures the 32-bit store data driven by the memory/IO interface whenever an I/O write targets its address. It then time-multiplexes the eight hex nibbles onto a common-anode, active-low display. Sits directly downstream of the memory/IO interface, in parallel with data memory.

## Interface
- `SEG_ADDR`, default 32'hFFFF_FC60: I/O address that selects this block.
- `SCAN_DIV`, default 100000: clock cycles each digit stays lit; legal range 1..2^20.
- `clk`  in  1: system clock; all state updates on the rising edge.
- `rst_n`  in  1: reset; one clock; reset is synchronous and active-low.
- `io_write`  in  1: I/O write strobe for the current cycle.
- `addr`  in  32: byte address of the current access.
- `w_data`  in  32: store data; valid while `io_write`=1.
- `seg_en`  out  8: digit enables, active-low; bit i selects digit i, rightmost digit is 0.
- `seg_out`  out  8: segments {dp,g,f,e,d,c,b,a}, active-low.

## Operation
- **Capture.** When `io_write`=1 and `addr`==`SEG_ADDR` (full 32-bit compare) at an edge, load `w_data` into the 32-bit display register. Any other access leaves the register unchanged. No read-back.
- **Scan divider.** `div_cnt` counts 0..`SCAN_DIV`-1.
  - At terminal count it returns to 0 and the 3-bit digit index advances.
  - The index wraps 7→0.
  - With `SCAN_DIV`=1 the index advances every cycle.
- **Digit select.** Digit i displays nibble `disp[4i+3:4i]`.
- **Hex decode.** 0..F map to the standard glyphs, dp always off (bit 7 = 1). Anchor codes:
  - 0=8'hC0, 1=8'hF9, 2=8'hA4, 3=8'hB0
  - 8=8'h80, 9=8'h90, A=8'h88
  - b=8'h83, C=8'hC6, d=8'hA1, E=8'h86, F=8'h8E
- **Output drive.** Exactly one `seg_en` bit is low at any time after the first post-reset edge (unless blanked, see Configuration). `seg_en` = ~(8'b1 << index).
- **Reset state.**
  - Display register = 0, `div_cnt` = 0, index = 0.
  - Outputs `seg_en` = 8'hFF and `seg_out` = 8'hFF, all dark.
  - Reset asserted mid-scan returns everything to these values at the next edge.

## Timing
- `seg_en`/`seg_out` are registered. They are computed from the index and display register as they stand before the edge, so there is one cycle of latency.
- A write captured at edge k is visible on `seg_out` at edge k+1 if its digit is currently selected.
- An index advance at edge k shows the new digit at edge k+1.
- A write and an index advance on the same edge both take effect. The output at edge k+1 shows the new data on the new digit.
- First edge with `rst_n`=1: outputs are still computed from the reset state, so `seg_en`=8'hFE and `seg_out`=8'hC0.
- Each digit is lit for exactly `SCAN_DIV` cycles per frame. The frame period is 8·`SCAN_DIV` cycles.
- `io_write` is a single-cycle strobe. Holding it for N cycles re-captures each cycle, and the last value wins.

## Configuration
- Macro: `SEG_BLANK_LEADING_ZERO_EN`.
- **Defined.** Digits above the highest non-zero nibble are blanked: `seg_en` = 8'hFF and `seg_out` = 8'hFF for their scan slots. Digit 0 is always shown, so a value of 0 displays a single "0". Slot timing is unchanged.
- **Undefined.** All eight digits are always driven, with leading zeros shown.

## Test plan
- **Reset.** Hold `rst_n`=0 for 3 cycles → `seg_en`=8'hFF, `seg_out`=8'hFF. Release → next edge `seg_en`=8'hFE, `seg_out`=8'hC0.
- **Address decode.** `SCAN_DIV`=4; write 32'h1234_ABCD with `addr`=`SEG_ADDR`, then `addr`=`SEG_ADDR`+4 with 32'hFFFF_FFFF. Required `seg_out` sequence over digits 0..7:
  - digits 0..3: 8'hA1, 8'hC6, 8'h83, 8'h88
  - digits 4..7: 8'h99, 8'hB0, 8'hA4, 8'hF9
  - the second write is ignored.
- **Slot length.** `SCAN_DIV`=4: each `seg_en` value is held exactly 4 cycles, and the index wraps from 8'h7F back to 8'hFE.
- **Simultaneous events.** Write 32'h0000_0009 on the same edge the index advances to 0 → next edge `seg_en`=8'hFE, `seg_out`=8'h90.
- **Reset mid-scan.** Pulse `rst_n` low while digit 5 is lit → dark next edge, then restarts at digit 0 with display value 0.
- **Blanking.** With `SEG_BLANK_LEADING_ZERO_EN`, write 32'h0000_0042:
  - digit slots 0–1 show 8'hA4 and 8'h99;
  - slots 2–7 give `seg_en`=8'hFF.
  - Writing 0 shows only digit 0 as 8'hC0.

Source files
------------

// File: rtl/seg7_out.sv
// seg7_out: memory-mapped eight-digit seven-segment display controller.
// Captures 32-bit store data on an I/O write to SEG_ADDR and time-multiplexes
// the eight hex nibbles onto a common-anode, active-low display.
// Optional feature macro: SEG_BLANK_LEADING_ZERO_EN (blanks digits above the
// highest non-zero nibble; digit 0 is always shown).
// Handshake: io_write is a plain per-cycle strobe with no ready/back-pressure;
// a write is accepted on any edge where io_write=1 and addr==SEG_ADDR.
module seg7_out #(
    parameter logic [31:0] SEG_ADDR = 32'hFFFF_FC60,
    parameter int          SCAN_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        io_write,
    input  logic [31:0] addr,
    input  logic [31:0] w_data,
    output logic [7:0]  seg_en,
    output logic [7:0]  seg_out
);

    // SCAN_DIV is at most 2^20, so the terminal count fits in 20 bits.
    localparam logic [19:0] DIV_LAST = 20'(SCAN_DIV - 1);

    logic [31:0] r_disp;
    logic [19:0] r_div_cnt;
    logic [2:0]  r_idx;
    logic [7:0]  r_seg_en;
    logic [7:0]  r_seg_out;

    logic        w_capture;
    logic        w_div_last;
    logic [19:0] w_div_next;
    logic [2:0]  w_idx_next;
    logic [31:0] w_disp_next;
    logic [3:0]  w_nibble;
    logic [7:0]  w_en_next;
    logic [7:0]  w_seg_next;

    // Standard hex glyphs, segments {dp,g,f,e,d,c,b,a}, active-low, dp off.
    function automatic logic [7:0] hex_glyph(input logic [3:0] n);
        logic [7:0] g;
        g = 8'hFF;
        case (n)
            4'h0: g = 8'hC0;
            4'h1: g = 8'hF9;
            4'h2: g = 8'hA4;
            4'h3: g = 8'hB0;
            4'h4: g = 8'h99;
            4'h5: g = 8'h92;
            4'h6: g = 8'h82;
            4'h7: g = 8'hF8;
            4'h8: g = 8'h80;
            4'h9: g = 8'h90;
            4'hA: g = 8'h88;
            4'hB: g = 8'h83;
            4'hC: g = 8'hC6;
            4'hD: g = 8'hA1;
            4'hE: g = 8'h86;
            4'hF: g = 8'h8E;
        endcase
        return g;
    endfunction

    // Next-state logic: address decode, scan divider and digit index advance.
    always_comb begin
        w_capture   = io_write && (addr == SEG_ADDR);
        w_div_last  = (r_div_cnt == DIV_LAST);
        w_div_next  = w_div_last ? 20'd0 : r_div_cnt + 20'd1;
        w_idx_next  = w_div_last ? r_idx + 3'd1 : r_idx;
        w_disp_next = w_capture ? w_data : r_disp;
    end

`ifdef SEG_BLANK_LEADING_ZERO_EN
    logic [2:0] w_top;

    // Position of the highest non-zero nibble; 0 when the value is zero so
    // that digit 0 always remains visible.
    always_comb begin
        w_top = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (r_disp[4*i +: 4] != 4'h0) begin
                w_top = 3'(i);
            end
        end
    end
`endif

    // Output decode from the index and display register as they stand now;
    // the result is registered, giving one cycle of latency.
    always_comb begin
        w_nibble   = r_disp[{r_idx, 2'b00} +: 4];
        w_en_next  = ~(8'd1 << r_idx);
        w_seg_next = hex_glyph(w_nibble);
`ifdef SEG_BLANK_LEADING_ZERO_EN
        if (r_idx > w_top) begin
            w_en_next  = 8'hFF;
            w_seg_next = 8'hFF;
        end
`endif
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_disp    <= 32'd0;
            r_div_cnt <= 20'd0;
            r_idx     <= 3'd0;
            r_seg_en  <= 8'hFF;
            r_seg_out <= 8'hFF;
        end else begin
            r_disp    <= w_disp_next;
            r_div_cnt <= w_div_next;
            r_idx     <= w_idx_next;
            r_seg_en  <= w_en_next;
            r_seg_out <= w_seg_next;
        end
    end

    assign seg_en  = r_seg_en;
    assign seg_out = r_seg_out;

endmodule

// File: tb/tb_seg7_out.sv
// tb_seg7_out: randomized bench for seg7_out with a cycle-level reference
// model (time-since-reset arithmetic) feeding an expected queue, and a
// monitor that pops and compares every cycle.
module tb_seg7_out;

  localparam logic [31:0] SEG_ADDR = 32'hFFFF_FC60;
  localparam int          SCAN_DIV = 4;

  // ---------------- clock / reset ----------------
  logic        clk      = 1'b0;
  logic        rst_n    = 1'b0;
  logic        io_write = 1'b0;
  logic [31:0] addr     = 32'd0;
  logic [31:0] w_data   = 32'd0;
  logic [7:0]  seg_en;
  logic [7:0]  seg_out;

  always #5 clk = ~clk;

  seg7_out #(
    .SEG_ADDR (SEG_ADDR),
    .SCAN_DIV (SCAN_DIV)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .io_write (io_write),
    .addr     (addr),
    .w_data   (w_data),
    .seg_en   (seg_en),
    .seg_out  (seg_out)
  );

  // ---------------- reference model ----------------
  logic [15:0] exp_q[$];
  int          n_cmp  = 0;
  int          n_err  = 0;
  int          cyc    = 0;
  int          m_t    = 0;      // cycles since reset release, for the next edge
  logic [31:0] m_disp = 32'd0;

  logic [7:0] glyph [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                             8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  function automatic logic [15:0] ref_out(input int t, input logic [31:0] d);
    int         digit;
    int         nib;
    int         top;
    logic [7:0] en;
    digit = (t / SCAN_DIV) % 8;
    nib   = int'((d >> (4 * digit)) & 32'hF);
    en    = 8'hFF;
    en[digit] = 1'b0;
    top = 0;
    for (int i = 7; i >= 0; i--) begin
      if (top == 0 && ((d >> (4 * i)) & 32'hF) != 0) top = i;
    end
`ifdef SEG_BLANK_LEADING_ZERO_EN
    if (digit > top) return 16'hFFFF;
`endif
    return {en, glyph[nib[3:0]]};
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      exp_q.push_back(16'hFFFF);
      m_t    = 0;
      m_disp = 32'd0;
    end else begin
      exp_q.push_back(ref_out(m_t, m_disp));
      if (io_write && addr == SEG_ADDR) m_disp = w_data;
      m_t++;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [15:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if ({seg_en, seg_out} !== e) begin
        n_err++;
        $display("FAIL seg_outputs cycle %0d: got en=%h seg=%h, required en=%h seg=%h",
                 cyc, seg_en, seg_out, e[15:8], e[7:0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write_cycle(input logic [31:0] a, input logic [31:0] d);
    io_write = 1'b1;
    addr     = a;
    w_data   = d;
    @(negedge clk);
    io_write = 1'b0;
  endtask

  task automatic wait_phase(input int period, input int phase);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 4 * period && !found; i++) begin
      if ((m_t % period) == phase) found = 1'b1;
      else @(negedge clk);
    end
    n_cmp++;
    if (!found) begin
      n_err++;
      $display("FAIL wait_phase: got no phase %0d, required phase %0d of %0d", m_t % period, phase, period);
    end
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int          sel;
    logic [31:0] d;
    idle(3);
    rst_n = 1'b1;
    idle(40);

    // address decode: only the exact address captures
    write_cycle(SEG_ADDR, 32'h1234_ABCD);
    write_cycle(SEG_ADDR + 32'd4, 32'hFFFF_FFFF);
    idle(36);

    // strobe low at the matching address must not capture
    addr   = SEG_ADDR;
    w_data = 32'hDEAD_BEEF;
    idle(8);
    addr   = 32'd0;

    // write on the same edge the index wraps to digit 0
    wait_phase(8 * SCAN_DIV, 8 * SCAN_DIV - 1);
    write_cycle(SEG_ADDR, 32'h0000_0009);
    idle(34);

    // reset pulse while digit 5 is lit
    wait_phase(8 * SCAN_DIV, 5 * SCAN_DIV + 1);
    reset_pulse();
    idle(40);

    // leading-zero patterns
    write_cycle(SEG_ADDR, 32'h0000_0042);
    idle(34);
    write_cycle(SEG_ADDR, 32'h0000_0000);
    idle(34);
    write_cycle(SEG_ADDR, 32'h00F0_0000);
    idle(34);

    // held strobe: last value wins
    io_write = 1'b1;
    addr     = SEG_ADDR;
    w_data   = 32'h1111_1111;
    @(negedge clk);
    w_data   = 32'h2222_2222;
    @(negedge clk);
    w_data   = 32'h3456_789A;
    @(negedge clk);
    io_write = 1'b0;
    idle(34);

    // randomized mix
    for (int k = 0; k < 40; k++) begin
      sel = $urandom_range(0, 9);
      d   = $urandom;
      if (sel <= 4) begin
        write_cycle(SEG_ADDR, d >> (4 * $urandom_range(0, 7)));
      end else if (sel <= 6) begin
        write_cycle(SEG_ADDR ^ (32'd1 << $urandom_range(0, 31)), d);
      end else if (sel == 7) begin
        addr   = SEG_ADDR;
        w_data = d;
        @(negedge clk);
      end else begin
        reset_pulse();
      end
      idle($urandom_range(0, 12));
    end
    idle(40);

    // every expected response must have been consumed
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL queue_drain: got %0d pending, required 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout at cycle %0d, required completion", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
